// File: rtl/boot_loader.sv
// Power-up sequencer: receives a length-prefixed big-endian image over the UART
// receive handshake, writes it into instruction memory, then issues the fetch start pulse.
module boot_loader #(
  parameter int ADDR_W       = 13,
  parameter int DELAY_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        uart_recv_data,
  input  logic              uart_recv_valid,
  output logic              uart_recv_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              imem_we,
  output logic              start_finish,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int          DW  = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [32:0] CAP = 33'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_HEADER, S_LOAD, S_WRITE, S_DELAY, S_START, S_DONE, S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic            run_q;
  logic [31:0]     shreg_q, shreg_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [ADDR_W:0] n_q, n_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [DW-1:0]   dly_q, dly_d;

  logic        fire;
  logic [31:0] assembled;

  // run_q holds ready low until the first edge after reset release.
  assign uart_recv_ready = run_q && (state_q == S_HEADER || state_q == S_LOAD);
  assign fire            = uart_recv_valid && uart_recv_ready;
  assign assembled       = {shreg_q[23:0], uart_recv_data};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_HEADER;
      run_q   <= 1'b0;
      shreg_q <= '0;
      bcnt_q  <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    case (state_q)
      S_HEADER: if (fire) begin
        shreg_d = assembled;
        bcnt_d  = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          if (assembled == 32'd0) begin
            state_d = S_DELAY;
            dly_d   = '0;
          end else if ({1'b0, assembled} > CAP) begin
            state_d = S_ERROR;
          end else begin
            // Fits in ADDR_W+1 bits once bounded by the capacity check.
            n_d     = assembled[ADDR_W:0];
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: if (fire) begin
        shreg_d = assembled;
        bcnt_d  = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == n_q) begin
          state_d = S_DELAY;
          dly_d   = '0;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DELAY: begin
        if (dly_q == DW'(DELAY_CYCLES - 1)) state_d = S_START;
        else                                dly_d   = dly_q + 1'b1;
      end
      S_START: state_d = S_DONE;
      default: state_d = state_q;
    endcase
  end

  assign imem_we      = (state_q == S_WRITE);
  assign imem_addr    = imem_we ? cnt_q[ADDR_W-1:0] : '0;
  assign imem_wdata   = imem_we ? shreg_q : '0;
  assign start_finish = (state_q == S_START);
  assign busy         = !(state_q == S_START || state_q == S_DONE);
  assign err          = (state_q == S_ERROR);
  assign word_cnt     = cnt_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: image vectors from a table plus reset/DONE sequences.
module tb_boot_loader;
  localparam int ADDR_W = 13;
  localparam int DLY    = 1000;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [7:0]        uart_recv_data = 8'h00;
  logic              uart_recv_valid = 1'b0;
  logic              uart_recv_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_we;
  logic              start_finish;
  logic              busy;
  logic              err;
  logic [ADDR_W:0]   word_cnt;

  boot_loader #(.ADDR_W(ADDR_W), .DELAY_CYCLES(DLY)) dut (
    .clk(clk), .rstn(rstn),
    .uart_recv_data(uart_recv_data), .uart_recv_valid(uart_recv_valid),
    .uart_recv_ready(uart_recv_ready),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_we(imem_we),
    .start_finish(start_finish), .busy(busy), .err(err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Event logs, sampled mid-cycle; cycle stamps are the cycle the event is visible.
  int          acc_cyc[$];
  logic [7:0]  acc_dat[$];
  int          wr_cyc[$];
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          st_cyc[$];
  logic        st_busy[$];
  logic        st_prev_busy[$];
  logic        last_busy = 1'b1;

  always @(negedge clk) begin
    if (rstn) begin
      if (uart_recv_valid && uart_recv_ready) begin
        acc_cyc.push_back(cyc);
        acc_dat.push_back(uart_recv_data);
      end
      if (imem_we) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(int'(imem_addr));
        wr_data.push_back(imem_wdata);
      end
      if (start_finish) begin
        st_cyc.push_back(cyc);
        st_busy.push_back(busy);
        st_prev_busy.push_back(last_busy);
      end
    end
    last_busy = busy;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_logs();
    acc_cyc.delete(); acc_dat.delete();
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
    st_cyc.delete(); st_busy.delete(); st_prev_busy.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 64'(uart_recv_ready), 64'd0);
    chk({tag, "_we"},    64'(imem_we),         64'd0);
    chk({tag, "_addr"},  64'(imem_addr),       64'd0);
    chk({tag, "_wdata"}, 64'(imem_wdata),      64'd0);
    chk({tag, "_start"}, 64'(start_finish),    64'd0);
    chk({tag, "_busy"},  64'(busy),            64'd1);
    chk({tag, "_err"},   64'(err),             64'd0);
    chk({tag, "_wcnt"},  64'(word_cnt),        64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    uart_recv_valid = 1'b0;
    rstn = 1'b0;
    #1;
    check_reset_vals("rst");
    repeat (3) @(negedge clk);
    clear_logs();
    rstn = 1'b1;
    #1;
    chk("ready_before_edge", 64'(uart_recv_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_edge", 64'(uart_recv_ready), 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    @(negedge clk);
    if (gap > 0) begin
      uart_recv_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    uart_recv_data  = b;
    uart_recv_valid = 1'b1;
    t = 0;
    while (!uart_recv_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: got ready=0 for %0d cycles expected 1", t);
    end
    @(posedge clk);
  endtask

  task automatic wait_start(input int limit);
    int t = 0;
    while (st_cyc.size() == 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (st_cyc.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL start_timeout: got no start_finish in %0d cycles expected one", limit);
    end
  endtask

  typedef struct {
    logic [127:0] bytes;   // byte k at [127-8k -: 8]
    int           nb;
    int           maxgap;
    int           exp_nw;
    logic [95:0]  exp_w;   // word j at [95-32j -: 32]
    bit           exp_err;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int i, input vec_t v);
    int ref_cyc;
    do_reset();
    for (int k = 0; k < v.nb; k++)
      send_byte(v.bytes[127-8*k -: 8], (v.maxgap > 0) ? int'($urandom_range(0, v.maxgap)) : 0);
    @(negedge clk);
    uart_recv_valid = 1'b0;
    chk($sformatf("v%0d_nacc", i), 64'(acc_dat.size()), 64'(v.nb));
    for (int k = 0; k < v.nb && k < acc_dat.size(); k++)
      chk($sformatf("v%0d_acc%0d", i, k), 64'(acc_dat[k]), 64'(v.bytes[127-8*k -: 8]));
    if (v.exp_err) begin
      chk($sformatf("v%0d_err", i),   64'(err),             64'd1);
      chk($sformatf("v%0d_ready", i), 64'(uart_recv_ready), 64'd0);
      repeat (5000) @(negedge clk);
      chk($sformatf("v%0d_nstart", i), 64'(st_cyc.size()), 64'd0);
      chk($sformatf("v%0d_nwr", i),    64'(wr_cyc.size()), 64'd0);
      chk($sformatf("v%0d_err_hold", i), 64'(err),  64'd1);
      chk($sformatf("v%0d_busy", i),     64'(busy), 64'd1);
    end else begin
      wait_start(3000);
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_nwr", i), 64'(wr_cyc.size()), 64'(v.exp_nw));
      for (int j = 0; j < v.exp_nw && j < wr_cyc.size(); j++) begin
        chk($sformatf("v%0d_waddr%0d", i, j), 64'(wr_addr[j]), 64'(j));
        chk($sformatf("v%0d_wdata%0d", i, j), 64'(wr_data[j]), 64'(v.exp_w[95-32*j -: 32]));
        if (acc_cyc.size() > 4*j + 7)
          chk($sformatf("v%0d_wcyc%0d", i, j), 64'(wr_cyc[j]), 64'(acc_cyc[4*j+7] + 1));
      end
      chk($sformatf("v%0d_nstart", i), 64'(st_cyc.size()), 64'd1);
      if (st_cyc.size() > 0 && acc_cyc.size() >= 4) begin
        ref_cyc = (v.exp_nw > 0 && wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] : acc_cyc[3];
        chk($sformatf("v%0d_start_lat", i), 64'(st_cyc[0] - ref_cyc), 64'(DLY + 1));
        chk($sformatf("v%0d_busy_at_start", i), 64'(st_busy[0]), 64'd0);
        chk($sformatf("v%0d_busy_before", i),   64'(st_prev_busy[0]), 64'd1);
      end
      chk($sformatf("v%0d_wcnt", i), 64'(word_cnt), 64'(v.exp_nw));
      chk($sformatf("v%0d_busy_done", i), 64'(busy), 64'd0);
      chk($sformatf("v%0d_err", i), 64'(err), 64'd0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr;
    vecs[0] = '{128'h00000002_DEADBEEF_01020304_00000000, 12, 0, 2,
                96'hDEADBEEF_01020304_00000000, 1'b0};
    vecs[1] = '{128'h00000000_00000000_00000000_00000000, 4, 0, 0,
                96'h0, 1'b0};
    vecs[2] = '{128'h00002001_00000000_00000000_00000000, 4, 0, 0,
                96'h0, 1'b1};
    vecs[3] = '{128'h00000001_12345678_00000000_00000000, 8, 7, 1,
                96'h12345678_00000000_00000000, 1'b0};
    vecs[4] = '{128'h00000003_AABBCCDD_00FF00FF_80000001, 16, 2, 3,
                96'hAABBCCDD_00FF00FF_80000001, 1'b0};

    for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

    // Reset mid-image: N=3, abort after 6 data bytes.
    do_reset();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    @(negedge clk);
    uart_recv_valid = 1'b0;
    nwr = wr_cyc.size();
    chk("abort_nwr", 64'(nwr), 64'd1);
    if (nwr > 0) chk("abort_w0", 64'(wr_data[0]), 64'h11223344);
    chk("abort_wcnt", 64'(word_cnt), 64'd1);
    rstn = 1'b0;
    #1;
    check_reset_vals("abort");
    repeat (3) @(negedge clk);
    chk("abort_nwr_after", 64'(wr_cyc.size()), 64'd1);
    rstn = 1'b1;
    clear_logs();
    @(negedge clk);
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hCA, 1); send_byte(8'hFE, 0); send_byte(8'hF0, 3); send_byte(8'h0D, 0);
    @(negedge clk);
    uart_recv_valid = 1'b0;
    wait_start(3000);
    repeat (3) @(negedge clk);
    chk("fresh_nwr", 64'(wr_cyc.size()), 64'd1);
    if (wr_cyc.size() > 0) begin
      chk("fresh_addr", 64'(wr_addr[0]), 64'd0);
      chk("fresh_data", 64'(wr_data[0]), 64'hCAFEF00D);
    end
    chk("fresh_nstart", 64'(st_cyc.size()), 64'd1);
    if (st_cyc.size() > 0 && wr_cyc.size() > 0)
      chk("fresh_start_lat", 64'(st_cyc[0] - wr_cyc[0]), 64'(DLY + 1));

    // DONE: bytes offered indefinitely are never consumed.
    uart_recv_data  = 8'h55;
    uart_recv_valid = 1'b1;
    repeat (60) @(negedge clk);
    chk("done_ready",  64'(uart_recv_ready), 64'd0);
    chk("done_nacc",   64'(acc_cyc.size()),  64'd8);
    chk("done_nwr",    64'(wr_cyc.size()),   64'd1);
    chk("done_nstart", 64'(st_cyc.size()),   64'd1);
    chk("done_busy",   64'(busy),            64'd0);
    uart_recv_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
